gate_seq: RTL and testbench
===========================

Name: gate_seq

Overview:
- Upstream sequencer for the label store/fetch controller.
- Walks the gate list in a synchronous gate ROM. For each gate it drives the fetch/store strobes with the right wire IDs and waits on the controller's done.
- Routes AND gates through the garbled-table evaluator. Writes each output wire label back to the label store.
- Sits between the top-level run control and the label controller / AND evaluator.

Parameters:
- ID_W, 13, wire ID width.
- GADDR_W, 13, gate ROM address width.
- LABEL_W, 128, wire label width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begin a run (ignored unless IDLE)
- num_gates  in  GADDR_W  gate count; sampled on start
- busy  out  1  high from the cycle after an accepted start until run_done
- run_done  out  1  one-cycle pulse at end of run
- error  out  1  sticky; set by reserved gate type; cleared on next accepted start
- gate_addr  out  GADDR_W  gate ROM address
- gate_rd_en  out  1  ROM read enable; data valid one cycle later
- gate_rd_data  in  41  [40:39] type, [38:26] in_a, [25:13] in_b, [12:0] out_id
- wire_id_read  out  ID_W  fetch wire ID
- id_1_strobe  out  1  fetch first input
- id_2_strobe  out  1  fetch second input and combine
- gate_type  out  2  0 AND, 1 XOR, 2 BUF; held for whole gate
- wire_id_write  out  ID_W  store wire ID
- store_strobe  out  1  store label_in
- label_in  out  LABEL_W  label to store
- ctl_done  in  1  controller completion pulse
- ctl_label  in  LABEL_W  controller label output
- ctl_point  in  2  point-and-permute pointer
- eval_start  out  1  one-cycle pulse to AND evaluator
- eval_label_in  out  LABEL_W  plaintext/key to evaluator (= ctl_label captured after FETCH_2)
- eval_point  out  2  captured ctl_point
- eval_done  in  1  evaluator completion pulse
- eval_label  in  LABEL_W  evaluated output label

Behaviour:
- Reset: state IDLE. All of the following are 0:
  - busy, run_done, error, all strobes, eval_start
  - gate_addr, wire_id_read, wire_id_write, label_in, gate_type, eval_label_in, eval_point
  - internal gate counter.
- Reset mid-run aborts immediately; no further strobes issue.
- All strobes and eval_start are registered one-cycle pulses. At most one is high per cycle.
- Hold rules:
  - wire_id_read is stable from a fetch strobe until ctl_done.
  - wire_id_write and label_in are stable from store_strobe until ctl_done.
  - gate_type is stable for the whole gate.
- States:
  - IDLE: on start:
    - num_gates==0: pulse run_done next cycle; busy stays 0.
    - otherwise: latch num_gates, idx=0, busy=1, go RD.
  - RD: gate_rd_en=1, gate_addr=idx, go LATCH.
  - LATCH: register the descriptor fields and drive gate_type.
    - type 3: set error, skip the gate, go NEXT.
    - otherwise: wire_id_read=in_a, go F1.
  - F1: pulse id_1_strobe, go W1.
  - W1: wait ctl_done.
    - BUF: label_in=ctl_label, go ST.
    - else: wire_id_read=in_b, go F2.
  - F2: pulse id_2_strobe, go W2.
  - W2: wait ctl_done.
    - XOR: label_in=ctl_label, go ST.
    - AND: eval_label_in=ctl_label, eval_point=ctl_point, go EV.
  - EV: pulse eval_start, go WE.
  - WE: wait eval_done; label_in=eval_label; go ST.
  - ST: wire_id_write=out_id, pulse store_strobe, go WS.
  - WS: wait ctl_done, go NEXT.
  - NEXT: idx+1.
    - If idx+1==latched count: pulse run_done, busy=0, IDLE.
    - Else: RD.
- ctl_done or eval_done outside its wait state is ignored.
- start while busy is ignored.
- Gate indices 0..num_gates-1 are processed strictly in order. No wrap-around.
- Per-gate overhead (excluding controller/evaluator waits): 4 cycles RD..F1, +2 per extra fetch, +2 eval, +2 store, +1 NEXT.

Test Plan:
- XOR gate (type 1, in_a=5, in_b=6, out=7); ctl_done 3 cycles after each strobe; F2 returns ctl_label=0xA5..A5 -> strobe sequence id_1(5), id_2(6), store(7) with label_in=0xA5..A5; eval_start never pulses; run_done pulses once.
- AND gate (type 0, in 1,2, out 3); ctl_point=2'b10; eval_label=0x1234 -> eval_start once with eval_point=2'b10; store_strobe with wire 3 and label_in=0x1234 only after eval_done.
- BUF gate (type 2, in 9, out 10) -> one fetch only (no id_2_strobe); store to 10 with the F1 label.
- num_gates=3 with types AND/XOR/BUF -> gate_addr reads 0,1,2 in order; busy high throughout; run_done exactly once; error=0.
- Type-3 gate at index 1 of 2 -> error=1; no strobes for that gate; run completes. A following start clears error.
- rst asserted during WE of an AND gate -> next cycle all outputs 0, state IDLE; a late eval_done is ignored; a fresh start runs cleanly.

Source files
------------

// File: rtl/gate_seq.sv
// gate_seq: walks the gate ROM one descriptor at a time, fetching the input
// labels through the label controller, routing AND gates through the
// garbled-table evaluator and storing each output label back.
module gate_seq #(
    parameter int ID_W    = 13,
    parameter int GADDR_W = 13,
    parameter int LABEL_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [GADDR_W-1:0] num_gates,
    output logic               busy,
    output logic               run_done,
    output logic               error,
    output logic [GADDR_W-1:0] gate_addr,
    output logic               gate_rd_en,
    input  logic [40:0]        gate_rd_data,
    output logic [ID_W-1:0]    wire_id_read,
    output logic               id_1_strobe,
    output logic               id_2_strobe,
    output logic [1:0]         gate_type,
    output logic [ID_W-1:0]    wire_id_write,
    output logic               store_strobe,
    output logic [LABEL_W-1:0] label_in,
    input  logic               ctl_done,
    input  logic [LABEL_W-1:0] ctl_label,
    input  logic [1:0]         ctl_point,
    output logic               eval_start,
    output logic [LABEL_W-1:0] eval_label_in,
    output logic [1:0]         eval_point,
    input  logic               eval_done,
    input  logic [LABEL_W-1:0] eval_label
);

    localparam logic [1:0] T_AND = 2'd0;
    localparam logic [1:0] T_XOR = 2'd1;
    localparam logic [1:0] T_BUF = 2'd2;
    localparam logic [1:0] T_RSV = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_LATCH, S_F1, S_W1, S_F2, S_W2,
        S_EV, S_WE, S_ST, S_WS, S_NEXT
    } state_t;

    state_t             r_state;
    logic [GADDR_W-1:0] r_idx;
    logic [GADDR_W-1:0] r_count;
    logic [ID_W-1:0]    r_in_b;
    logic [ID_W-1:0]    r_out_id;
    logic               r_busy, r_run_done, r_error, r_gate_rd_en;
    logic               r_id_1, r_id_2, r_store, r_eval_start;
    logic [GADDR_W-1:0] r_gate_addr;
    logic [ID_W-1:0]    r_wire_id_read, r_wire_id_write;
    logic [1:0]         r_gate_type, r_eval_point;
    logic [LABEL_W-1:0] r_label_in, r_eval_label_in;

    // Descriptor fields as presented by the ROM one cycle after the read.
    logic [1:0]         w_d_type;
    logic [ID_W-1:0]    w_d_in_a, w_d_in_b, w_d_out;
    logic [GADDR_W:0]   w_idx_inc;

    assign w_d_type  = gate_rd_data[40:39];
    assign w_d_in_a  = gate_rd_data[38:26];
    assign w_d_in_b  = gate_rd_data[25:13];
    assign w_d_out   = gate_rd_data[12:0];
    assign w_idx_inc = {1'b0, r_idx} + 1'b1;

    // Sequencer: every output is a register; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_count         <= '0;
            r_in_b          <= '0;
            r_out_id        <= '0;
            r_busy          <= 1'b0;
            r_run_done      <= 1'b0;
            r_error         <= 1'b0;
            r_gate_rd_en    <= 1'b0;
            r_id_1          <= 1'b0;
            r_id_2          <= 1'b0;
            r_store         <= 1'b0;
            r_eval_start    <= 1'b0;
            r_gate_addr     <= '0;
            r_wire_id_read  <= '0;
            r_wire_id_write <= '0;
            r_gate_type     <= '0;
            r_eval_point    <= '0;
            r_label_in      <= '0;
            r_eval_label_in <= '0;
        end else begin
            r_run_done   <= 1'b0;
            r_gate_rd_en <= 1'b0;
            r_id_1       <= 1'b0;
            r_id_2       <= 1'b0;
            r_store      <= 1'b0;
            r_eval_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_error <= 1'b0;
                        if (num_gates == '0) begin
                            r_run_done <= 1'b1;
                        end else begin
                            r_count      <= num_gates;
                            r_idx        <= '0;
                            r_busy       <= 1'b1;
                            r_gate_addr  <= '0;
                            r_gate_rd_en <= 1'b1;
                            r_state      <= S_RD;
                        end
                    end
                end
                S_RD: r_state <= S_LATCH;
                S_LATCH: begin
                    r_gate_type <= w_d_type;
                    r_in_b      <= w_d_in_b;
                    r_out_id    <= w_d_out;
                    if (w_d_type == T_RSV) begin
                        // Reserved type: flag it and move on without touching wires.
                        r_error <= 1'b1;
                        r_state <= S_NEXT;
                    end else begin
                        r_wire_id_read <= w_d_in_a;
                        r_id_1         <= 1'b1;
                        r_state        <= S_F1;
                    end
                end
                S_F1: r_state <= S_W1;
                S_W1: begin
                    if (ctl_done) begin
                        if (r_gate_type == T_BUF) begin
                            r_label_in      <= ctl_label;
                            r_wire_id_write <= r_out_id;
                            r_store         <= 1'b1;
                            r_state         <= S_ST;
                        end else begin
                            r_wire_id_read <= r_in_b;
                            r_id_2         <= 1'b1;
                            r_state        <= S_F2;
                        end
                    end
                end
                S_F2: r_state <= S_W2;
                S_W2: begin
                    if (ctl_done) begin
                        if (r_gate_type == T_XOR) begin
                            r_label_in      <= ctl_label;
                            r_wire_id_write <= r_out_id;
                            r_store         <= 1'b1;
                            r_state         <= S_ST;
                        end else begin
                            // AND: the combined label becomes the evaluator key.
                            r_eval_label_in <= ctl_label;
                            r_eval_point    <= ctl_point;
                            r_eval_start    <= 1'b1;
                            r_state         <= S_EV;
                        end
                    end
                end
                S_EV: r_state <= S_WE;
                S_WE: begin
                    if (eval_done) begin
                        r_label_in      <= eval_label;
                        r_wire_id_write <= r_out_id;
                        r_store         <= 1'b1;
                        r_state         <= S_ST;
                    end
                end
                S_ST: r_state <= S_WS;
                S_WS: begin
                    if (ctl_done) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    r_idx <= w_idx_inc[GADDR_W-1:0];
                    if (w_idx_inc == {1'b0, r_count}) begin
                        r_run_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_gate_addr  <= w_idx_inc[GADDR_W-1:0];
                        r_gate_rd_en <= 1'b1;
                        r_state      <= S_RD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign run_done      = r_run_done;
    assign error         = r_error;
    assign gate_addr     = r_gate_addr;
    assign gate_rd_en    = r_gate_rd_en;
    assign wire_id_read  = r_wire_id_read;
    assign id_1_strobe   = r_id_1;
    assign id_2_strobe   = r_id_2;
    assign gate_type     = r_gate_type;
    assign wire_id_write = r_wire_id_write;
    assign store_strobe  = r_store;
    assign label_in      = r_label_in;
    assign eval_start    = r_eval_start;
    assign eval_label_in = r_eval_label_in;
    assign eval_point    = r_eval_point;

endmodule

// File: tb/tb_gate_seq.sv
// tb_gate_seq: randomized scoreboard bench for gate_seq. The stimulus side
// derives the expected event stream per gate from the gate-type rules; a
// negedge monitor pops and compares whenever the DUT emits an event.
module tb_gate_seq;
    localparam int ID_W = 13, GADDR_W = 13, LABEL_W = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start;
    logic [GADDR_W-1:0] num_gates;
    logic               busy, run_done, error, gate_rd_en;
    logic [GADDR_W-1:0] gate_addr;
    logic [40:0]        gate_rd_data;
    logic [ID_W-1:0]    wire_id_read, wire_id_write;
    logic               id_1_strobe, id_2_strobe, store_strobe, eval_start;
    logic [1:0]         gate_type, ctl_point, eval_point;
    logic [LABEL_W-1:0] label_in, ctl_label, eval_label_in, eval_label;
    logic               ctl_done, eval_done;

    gate_seq #(.ID_W(ID_W), .GADDR_W(GADDR_W), .LABEL_W(LABEL_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_gates(num_gates),
        .busy(busy), .run_done(run_done), .error(error),
        .gate_addr(gate_addr), .gate_rd_en(gate_rd_en), .gate_rd_data(gate_rd_data),
        .wire_id_read(wire_id_read), .id_1_strobe(id_1_strobe), .id_2_strobe(id_2_strobe),
        .gate_type(gate_type), .wire_id_write(wire_id_write), .store_strobe(store_strobe),
        .label_in(label_in), .ctl_done(ctl_done), .ctl_label(ctl_label), .ctl_point(ctl_point),
        .eval_start(eval_start), .eval_label_in(eval_label_in), .eval_point(eval_point),
        .eval_done(eval_done), .eval_label(eval_label)
    );

    // Gate ROM model with one-cycle read latency.
    logic [40:0] rom [0:63];
    logic [40:0] rom_q = '0;
    always @(posedge clk) if (gate_rd_en) rom_q <= rom[gate_addr[5:0]];
    assign gate_rd_data = rom_q;

    // Event kinds: 0 ROM read, 1 fetch 1, 2 fetch 2, 3 eval start, 4 store, 5 run done
    typedef struct { int kind; logic [12:0] id; logic [1:0] gt; logic [127:0] lab; logic [1:0] pt; logic err; } exp_t;
    typedef struct { logic [127:0] lab; logic [1:0] pt; int dly; } rsp_t;
    exp_t exp_q[$];
    rsp_t fetch_q[$];
    rsp_t eval_q[$];

    int tests = 0, fails = 0, done_cnt = 0, n_pulse;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void chk(string name, logic [127:0] act, logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    function automatic void push_exp(int k, logic [12:0] id, logic [1:0] gt, logic [127:0] lab, logic [1:0] pt, logic err);
        exp_t e;
        e.kind = k; e.id = id; e.gt = gt; e.lab = lab; e.pt = pt; e.err = err;
        exp_q.push_back(e);
    endfunction

    // Reference model: gate-by-gate event list, plus the responses the
    // controller/evaluator models will hand back in order.
    task automatic model_run(input int n);
        logic err; logic [1:0] t, p; logic [12:0] a, b, o; logic [127:0] l1, l2, ev; rsp_t r;
        err = 1'b0;
        for (int g = 0; g < n; g++) begin
            t = rom[g][40:39]; a = rom[g][38:26]; b = rom[g][25:13]; o = rom[g][12:0];
            push_exp(0, 13'(g), 2'd0, '0, 2'd0, 1'b0);
            if (t == 2'd3) begin err = 1'b1; continue; end
            l1 = rand128(); r.lab = l1; r.pt = 2'($urandom); r.dly = $urandom_range(1, 4);
            fetch_q.push_back(r);
            push_exp(1, a, t, '0, 2'd0, 1'b0);
            if (t == 2'd2) push_exp(4, o, t, l1, 2'd0, 1'b0);
            else begin
                l2 = rand128(); p = 2'($urandom);
                r.lab = l2; r.pt = p; r.dly = $urandom_range(1, 4);
                fetch_q.push_back(r);
                push_exp(2, b, t, '0, 2'd0, 1'b0);
                if (t == 2'd1) push_exp(4, o, t, l2, 2'd0, 1'b0);
                else begin
                    ev = rand128(); r.lab = ev; r.pt = 2'd0; r.dly = $urandom_range(1, 6);
                    eval_q.push_back(r);
                    push_exp(3, 13'd0, t, l2, p, 1'b0);
                    push_exp(4, o, t, ev, 2'd0, 1'b0);
                end
            end
        end
        push_exp(5, 13'd0, 2'd0, '0, 2'd0, err);
    endtask

    task automatic handle(input int k);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 128'(k), 128'(e.kind));
        case (k)
            0: begin chk("gate_addr", gate_addr, e.id); chk("busy_in_run", busy, 1); end
            1, 2: begin chk("fetch_wire_id", wire_id_read, e.id); chk("fetch_gate_type", gate_type, e.gt); end
            3: begin chk("eval_label_in", eval_label_in, e.lab); chk("eval_point", eval_point, e.pt); end
            4: begin chk("store_wire_id", wire_id_write, e.id); chk("store_label", label_in, e.lab);
                     chk("store_gate_type", gate_type, e.gt); end
            default: begin chk("done_error", error, e.err); chk("done_busy", busy, 0); done_cnt++; end
        endcase
    endtask

    // Monitor: compares every DUT event against the scoreboard head.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            n_pulse = int'(id_1_strobe) + int'(id_2_strobe) + int'(store_strobe) + int'(eval_start) + int'(run_done);
            if (n_pulse > 1) begin
                tests++; fails++;
                $display("FAIL one_hot_pulses: got %0d expected at most 1", n_pulse);
            end
            if (gate_rd_en)   handle(0);
            if (id_1_strobe)  handle(1);
            if (id_2_strobe)  handle(2);
            if (eval_start)   handle(3);
            if (store_strobe) handle(4);
            if (run_done)     handle(5);
        end
    end

    // Label controller model: answers fetches with queued labels, stores blindly.
    initial begin
        rsp_t r;
        ctl_done = 1'b0; ctl_label = '0; ctl_point = '0;
        @(negedge clk);
        forever begin
            if (rst !== 1'b1 && (id_1_strobe || id_2_strobe) && fetch_q.size() > 0) begin
                r = fetch_q.pop_front();
                repeat (r.dly) @(negedge clk);
                ctl_done = 1'b1; ctl_label = r.lab; ctl_point = r.pt;
                @(negedge clk);
                ctl_done = 1'b0; ctl_label = rand128(); ctl_point = 2'($urandom);
            end else if (rst !== 1'b1 && store_strobe) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                ctl_done = 1'b1;
                @(negedge clk);
                ctl_done = 1'b0;
            end else begin
                ctl_label = rand128(); ctl_point = 2'($urandom);
                @(negedge clk);
            end
        end
    end

    // Evaluator model.
    initial begin
        rsp_t r;
        eval_done = 1'b0; eval_label = '0;
        @(negedge clk);
        forever begin
            if (rst !== 1'b1 && eval_start && eval_q.size() > 0) begin
                r = eval_q.pop_front();
                repeat (r.dly) @(negedge clk);
                eval_done = 1'b1; eval_label = r.lab;
                @(negedge clk);
                eval_done = 1'b0; eval_label = rand128();
            end else begin
                eval_label = rand128();
                @(negedge clk);
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_ctrl", {busy, run_done, error, gate_rd_en, id_1_strobe, id_2_strobe,
                         store_strobe, eval_start, gate_type}, '0);
        chk("rst_ids", {gate_addr, wire_id_read, wire_id_write, eval_point}, '0);
        chk("rst_label_in", label_in, '0);
        chk("rst_eval_label_in", eval_label_in, '0);
    endtask

    task automatic run(input int n, input bit mid_start);
        int c0;
        model_run(n);
        c0 = done_cnt;
        @(negedge clk); start = 1'b1; num_gates = 13'(n);
        @(negedge clk); start = 1'b0; num_gates = 13'($urandom);
        if (mid_start && n > 0 && rom[0][40:39] != 2'd3) begin
            repeat (2) @(negedge clk);
            start = 1'b1; num_gates = 13'd1;
            @(negedge clk); start = 1'b0;
        end
        for (int c = 0; c < 3000 && done_cnt == c0; c++) @(negedge clk);
        chk("run_completed", 128'(done_cnt != c0), 1);
        repeat (2) @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 0);
        exp_q.delete(); fetch_q.delete(); eval_q.delete();
    endtask

    function automatic logic [40:0] gate(logic [1:0] t, logic [12:0] a, logic [12:0] b, logic [12:0] o);
        return {t, a, b, o};
    endfunction

    initial begin
        rsp_t r;
        rst = 1'b1; start = 1'b0; num_gates = '0;
        for (int i = 0; i < 64; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();

        rom[0] = gate(2'd1, 13'd5, 13'd6, 13'd7);   run(1, 1'b0);   // XOR
        rom[0] = gate(2'd0, 13'd1, 13'd2, 13'd3);   run(1, 1'b0);   // AND
        rom[0] = gate(2'd2, 13'd9, 13'd0, 13'd10);  run(1, 1'b0);   // BUF
        rom[0] = gate(2'd0, 13'd11, 13'd12, 13'd13);
        rom[1] = gate(2'd1, 13'd14, 13'd15, 13'd16);
        rom[2] = gate(2'd2, 13'd17, 13'd18, 13'd19);
        run(3, 1'b1);                                              // mixed, start while busy
        rom[0] = gate(2'd1, 13'd20, 13'd21, 13'd22);
        rom[1] = gate(2'd3, 13'd23, 13'd24, 13'd25);
        run(2, 1'b0);                                              // reserved type at index 1
        chk("error_sticky", error, 1);
        rom[0] = gate(2'd2, 13'd26, 13'd0, 13'd27);
        run(1, 1'b0);                                              // error clears on start
        run(0, 1'b0);                                              // zero gates

        // Reset while waiting on the evaluator; its late done must be ignored.
        rom[0] = gate(2'd0, 13'd1, 13'd2, 13'd3);
        r.lab = rand128(); r.pt = 2'd1; r.dly = 2; fetch_q.push_back(r);
        r.lab = rand128(); r.pt = 2'd2; r.dly = 2; fetch_q.push_back(r);
        r.lab = rand128(); r.pt = 2'd0; r.dly = 30; eval_q.push_back(r);
        push_exp(0, 13'd0, 2'd0, '0, 2'd0, 1'b0);
        push_exp(1, 13'd1, 2'd0, '0, 2'd0, 1'b0);
        push_exp(2, 13'd2, 2'd0, '0, 2'd0, 1'b0);
        push_exp(3, 13'd0, 2'd0, fetch_q[1].lab, 2'd2, 1'b0);
        @(negedge clk); start = 1'b1; num_gates = 13'd1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
        chk("reached_eval_wait", 128'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        repeat (40) @(negedge clk);
        chk("idle_after_late_eval_done", {busy, error}, 0);
        exp_q.delete(); fetch_q.delete(); eval_q.delete();
        run(1, 1'b0);                                              // fresh run after reset

        // Randomized runs, occasionally containing reserved gates.
        for (int k = 0; k < 10; k++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int g = 0; g < n; g++)
                rom[g] = gate(($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                              13'($urandom), 13'($urandom), 13'($urandom));
            run(n, k[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
